ex_muldiv_unit: RTL and testbench

- Parametrised multi-cycle RV32M execution unit beside the single-cycle EX ALU.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as an iterative shift-add multiplier and restoring divider.
- Stalls EX through busy_ex and returns the result to the MA-stage write-back path with a one-cycle done pulse.

---
 rtl/ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit placed beside the EX ALU.
//   Multiply: shift-add, MUL_UNROLL multiplier bits retired per CALC cycle.
//   Divide:   restoring, one quotient bit per CALC cycle.
//   Divide-by-zero and signed overflow finish from IDLE in one cycle.
// Optional build macro EXEC_MULDIV_EARLY_OUT_EN: also finishes from IDLE in one
//   cycle when a multiply operand is zero or |rs1| < |rs2| on div/rem.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid_ex      M-op present in EX (held while busy_ex)
//   funct3_ex         RV32M funct3
//   rs1/rs2_data_ex   operands
//   rd_adr_ex         destination register
//   flush_ex          cancel the op in flight
//   busy_ex           stall request to EX/ID/IF
//   done_ma           one-cycle result strobe
//   rd_adr_ma/rd_data_ma  result, valid while done_ma=1
//
// state | meaning
// IDLE  | waiting for a request; special cases resolved here
// CALC  | iterating multiply or divide steps
// FIX   | sign correction and result select
// DONE  | result strobe to MA
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic [4:0]      rd_adr_ex,
  input  logic            flush_ex,
  output logic            busy_ex,
  output logic            done_ma,
  output logic [4:0]      rd_adr_ma,
  output logic [XLEN-1:0] rd_data_ma
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        rd_adr_q, rd_adr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  logic              is_div_in, sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0]   mag1_in, mag2_in, min_val;
  logic              spec_hit;
  logic [XLEN-1:0]   spec_res;
  logic [2*XLEN-1:0] mul_step, div_step, prod;
  logic [XLEN:0]     sum, sh, diff;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign is_div_in = funct3_ex[2];
  assign sgn1_in   = (funct3_ex == 3'b001) || (funct3_ex == 3'b010) ||
                     (funct3_ex == 3'b100) || (funct3_ex == 3'b110);
  assign sgn2_in   = (funct3_ex == 3'b001) || (funct3_ex == 3'b100) ||
                     (funct3_ex == 3'b110);
  assign neg1_in   = sgn1_in & rs1_data_ex[XLEN-1];
  assign neg2_in   = sgn2_in & rs2_data_ex[XLEN-1];
  assign mag1_in   = neg1_in ? -rs1_data_ex : rs1_data_ex;
  assign mag2_in   = neg2_in ? -rs2_data_ex : rs2_data_ex;
  assign min_val   = {1'b1, {(XLEN-1){1'b0}}};

  // Cases whose result is known at accept time.
  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (is_div_in && (rs2_data_ex == '0)) begin
      spec_hit = 1'b1;
      spec_res = funct3_ex[1] ? rs1_data_ex : '1;
    end else if (is_div_in && !funct3_ex[0] && (rs1_data_ex == min_val) &&
                 (rs2_data_ex == '1)) begin
      spec_hit = 1'b1;
      spec_res = funct3_ex[1] ? '0 : min_val;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
    end else if (!is_div_in && ((rs1_data_ex == '0) || (rs2_data_ex == '0))) begin
      spec_hit = 1'b1;
      spec_res = '0;
    end else if (is_div_in && (mag1_in < mag2_in)) begin
      spec_hit = 1'b1;
      spec_res = funct3_ex[1] ? rs1_data_ex : '0;
`endif
    end
  end

  // Multiply: acc = {partial high, multiplier}; add multiplicand on lsb, shift right.
  always_comb begin
    sum      = '0;
    mul_step = acc_q;
    for (int k = 0; k < MUL_UNROLL; k++) begin
      sum      = {1'b0, mul_step[2*XLEN-1:XLEN]} + (mul_step[0] ? {1'b0, a_q} : '0);
      mul_step = {sum, mul_step[XLEN-1:1]};
    end
  end

  // Divide: acc = {remainder, dividend/quotient}; subtract sign decides restore.
  always_comb begin
    sh       = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = sh - {1'b0, b_q};
    div_step = {(diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]),
                acc_q[XLEN-2:0], ~diff[XLEN]};
  end

  always_comb begin
    prod = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo  = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])              fix_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rd_adr_d  = rd_adr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid_ex && !flush_ex) begin
          op_d   = funct3_ex;
          rd_d   = rd_adr_ex;
          neg1_d = neg1_in;
          neg2_d = neg2_in;
          a_d    = mag1_in;
          b_d    = mag2_in;
          if (spec_hit) begin
            rd_data_d = spec_res;
            rd_adr_d  = rd_adr_ex;
            state_d   = DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag1_in : mag2_in)};
            cnt_d   = is_div_in ? CW'(XLEN-1) : CW'(XLEN/MUL_UNROLL-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        rd_data_d = fix_res;
        rd_adr_d  = rd_q;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_ex) begin
      state_d   = IDLE;
      rd_adr_d  = rd_adr_q;
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rd_adr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rd_adr_q  <= rd_adr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign done_ma    = (state_q == DONE) && !flush_ex;
  assign busy_ex    = req_valid_ex && !done_ma;
  assign rd_adr_ma  = rd_adr_q;
  assign rd_data_ma = rd_data_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: table-driven vectors through a scoreboard queue on two
// instances (MUL_UNROLL=1 and MUL_UNROLL=4), plus hand-written flush/reset sequences.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req4, flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy1, done1, busy4, done4;
  logic [4:0]  rda1, rda4;
  logic [31:0] rdd1, rdd4;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_unit #(.XLEN(32), .MUL_UNROLL(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid_ex(req1), .funct3_ex(f3),
    .rs1_data_ex(rs1), .rs2_data_ex(rs2), .rd_adr_ex(rd), .flush_ex(flush),
    .busy_ex(busy1), .done_ma(done1), .rd_adr_ma(rda1), .rd_data_ma(rdd1));

  ex_muldiv_unit #(.XLEN(32), .MUL_UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid_ex(req4), .funct3_ex(f3),
    .rs1_data_ex(rs1), .rs2_data_ex(rs2), .rd_adr_ex(rd), .flush_ex(flush),
    .busy_ex(busy4), .done_ma(done4), .rd_adr_ma(rda4), .rd_data_ma(rdd4));

  localparam int L1  = 34;
  localparam int L4  = 10;
  localparam int LDV = 34;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
  localparam int LEO = 1;
`else
  localparam int LEO = 34;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          use4;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t q1[$];
  exp_t q4[$];
  vec_t vecs[$];
  exp_t e1, e4;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done1: got done at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        check("data1", rdd1, e1.data);
        check("rd1", {27'd0, rda1}, {27'd0, e1.rd});
        check("latency1", cyc, e1.cyc);
        check("busy_at_done1", {31'd0, busy1}, 32'd0);
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done4: got done at cycle %0d expected none", cyc);
      end else begin
        e4 = q4.pop_front();
        check("data4", rdd4, e4.data);
        check("rd4", {27'd0, rda4}, {27'd0, e4.rd});
        check("latency4", cyc, e4.cyc);
        check("busy_at_done4", {31'd0, busy4}, 32'd0);
      end
    end
  end

  task automatic add(input bit u4, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] r,
                     input logic [31:0] ex, input int lat);
    vec_t v;
    v.use4 = u4; v.f = f; v.a = a; v.b = b; v.r = r; v.exp = ex; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive a request at the start of a cycle (T0); req stays high.
  task automatic drive(input bit u4, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    @(posedge clk); #1;
    f3 = f; rs1 = a; rs2 = b; rd = r;
    if (u4) req4 = 1'b1; else req1 = 1'b1;
  endtask

  task automatic push_exp(input bit u4, input logic [31:0] ex, input logic [4:0] r,
                          input int lat);
    exp_t e;
    e.data = ex; e.rd = r; e.cyc = cyc + lat;
    if (u4) q4.push_back(e); else q1.push_back(e);
  endtask

  // Wait (bounded) for done; busy must stay high until then; drop req afterwards.
  task automatic wait_done(input bit u4);
    int n;
    bit busy_ok;
    busy_ok = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if ((u4 ? done4 : done1) === 1'b1) break;
      if ((u4 ? busy4 : busy1) !== 1'b1) busy_ok = 1'b0;
      n++;
      if (n > 100) break;
    end
    if (n > 100) begin
      checks++; failures++;
      $display("FAIL timeout: got no done within 100 cycles expected done");
      if (u4 && q4.size() > 0) void'(q4.pop_back());
      if (!u4 && q1.size() > 0) void'(q1.pop_back());
    end else begin
      check("busy_hold", {31'd0, busy_ok}, 32'd1);
    end
    @(posedge clk); #1;
    req1 = 1'b0; req4 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    rst = 1'b1; req1 = 1'b0; req4 = 1'b0; flush = 1'b0;
    f3 = 3'b000; rs1 = '0; rs2 = '0; rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_data", rdd1, 32'd0);
    check("rst_rd", {27'd0, rda1}, 32'd0);
    check("rst_busy_idle", {31'd0, busy1}, 32'd0);
    req1 = 1'b1; #1;
    check("rst_busy_follows_req", {31'd0, busy1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk) rst = 1'b0;

    add(0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, L1);
    add(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, L1);
    add(0, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, L1);
    add(0, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'hC000_0000, L1);
    add(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, L4);
    add(1, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, L4);
    add(1, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, L4);
    add(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1);
    add(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1);
    add(0, 3'b101, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'hFFFF_FFFF, 1);
    add(0, 3'b111, 32'h0000_0005, 32'h0000_0000, 5'd11, 32'h0000_0005, 1);
    add(0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFD, LDV);
    add(0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF, LDV);
    add(0, 3'b111, 32'h0000_0064, 32'h0000_0007, 5'd14, 32'h0000_0002, LDV);
    add(0, 3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, LDV);
    add(0, 3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 5'd16, 32'hFFFF_FFFE, LDV);
    add(0, 3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 5'd17, 32'hFFFF_FFFF, 1);
    add(0, 3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 5'd18, 32'hFFFF_FFFB, 1);
    add(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFF, L1);
    add(0, 3'b100, 32'h0000_0003, 32'h0000_000A, 5'd20, 32'h0000_0000, LEO);
    add(0, 3'b000, 32'h0000_0000, 32'h0000_1234, 5'd21, 32'h0000_0000, LEO);
    add(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'hFFFF_FFFE, L4);
    add(1, 3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 5'd23, 32'hFFFE_0001, L4);
    add(1, 3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 5'd24, 32'hFFFF_FFFF, L4);
    add(1, 3'b111, 32'h0000_0064, 32'h0000_0007, 5'd25, 32'h0000_0002, LDV);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].use4, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r);
      push_exp(vecs[i].use4, vecs[i].exp, vecs[i].r, vecs[i].lat);
      wait_done(vecs[i].use4);
    end

    // Flush at T10 of a DIV, MUL accepted at T11
    drive(0, 3'b100, 32'd1000, 32'd3, 5'd26);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk); if (done1) saw = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk); if (done1) saw = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_t10_no_done", {31'd0, saw}, 32'd0);
    f3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd27;
    push_exp(0, 32'd42, 5'd27, L1);
    wait_done(0);

    // Results hold outside DONE
    repeat (3) @(negedge clk);
    check("hold_data", rdd1, 32'd42);
    check("hold_rd", {27'd0, rda1}, 32'd27);

    // Flush coinciding with DONE
    drive(0, 3'b101, 32'd5, 32'd0, 5'd28);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_done", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req1 = 1'b0;

    // Flush in IDLE blocks acceptance
    drive(0, 3'b101, 32'd9, 32'd0, 5'd29);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req1 = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk); if (done1) saw = 1'b1;
    end
    check("flush_idle_blocks", {31'd0, saw}, 32'd0);

    // Asynchronous reset mid-operation
    drive(0, 3'b100, 32'd1000, 32'd3, 5'd30);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_done", {31'd0, done1}, 32'd0);
    check("rst_mid_data", rdd1, 32'd0);
    check("rst_mid_rd", {27'd0, rda1}, 32'd0);
    req1 = 1'b0;
    #1 rst = 1'b0;
    drive(0, 3'b111, 32'd100, 32'd7, 5'd31);
    push_exp(0, 32'd2, 5'd31, LDV);
    wait_done(0);

    repeat (40) @(negedge clk);
    check("queue1_empty", q1.size(), 32'd0);
    check("queue4_empty", q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
